// File: rtl/alu_exec_unit.sv
// ---------------------------------------------------------------------------
// alu_exec_unit
//
// Execution-side responder of the instruction window's issue handshake.
// Takes one instruction per order/accepted handshake, computes RV32I integer
// ALU results in a single cycle and RV32M MUL with a 32-step shift-add loop,
// then holds the result on the write-back port until the register manager
// acknowledges it. Work belonging to a killed context is silently dropped.
//
// Ports
//   clk, rst             : clock, synchronous active-high reset
//   order / accepted     : issue handshake (accepted is combinational)
//   e_exec_info          : packed {exec_type, io_type, func3, func7, pa_rd,
//                          d_rs1, d_rs2, context}, MSB first
//   branch_hazard,
//   hazard_context_info  : flush request and the contexts it kills
//   w_done, w_pa_rd,
//   w_data, w_context    : registered write-back result
//   w_ack                : write-back consumed this cycle
//   busy                 : unit is not idle
// ---------------------------------------------------------------------------
module alu_exec_unit #(
  parameter int LEN_WORD      = 32,
  parameter int LEN_PREG_ADDR = 6,
  parameter int LEN_CONTEXT   = 2,
  parameter int LEN_EXEC_TYPE = 5,
  parameter int LEN_EXEC_INFO = LEN_EXEC_TYPE + 1 + 3 + 7 + LEN_PREG_ADDR
                                + 2 * LEN_WORD + LEN_CONTEXT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     order,
  output logic                     accepted,
  input  logic [LEN_EXEC_INFO-1:0] e_exec_info,
  input  logic                     branch_hazard,
  input  logic [LEN_CONTEXT-1:0]   hazard_context_info,
  output logic                     w_done,
  output logic [LEN_PREG_ADDR-1:0] w_pa_rd,
  output logic [LEN_WORD-1:0]      w_data,
  output logic [LEN_CONTEXT-1:0]   w_context,
  input  logic                     w_ack,
  output logic                     busy
);

  // Bit positions of the packed exec info fields, LSB upward.
  localparam int CTX_LSB = 0;
  localparam int RS2_LSB = CTX_LSB + LEN_CONTEXT;
  localparam int RS1_LSB = RS2_LSB + LEN_WORD;
  localparam int RD_LSB  = RS1_LSB + LEN_WORD;
  localparam int F7_LSB  = RD_LSB + LEN_PREG_ADDR;
  localparam int F3_LSB  = F7_LSB + 7;
  localparam int IO_LSB  = F3_LSB + 3;
  localparam int ET_LSB  = IO_LSB + 1;

  localparam int SH_W  = $clog2(LEN_WORD);
  localparam int CNT_W = $clog2(LEN_WORD);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // Registered state
  // -------------------------------------------------------------------------
  state_e                   state_q,     state_d;
  logic [CNT_W-1:0]         cnt_q,       cnt_d;
  logic [LEN_WORD-1:0]      acc_q,       acc_d;
  logic [LEN_WORD-1:0]      mcand_q,     mcand_d;
  logic [LEN_WORD-1:0]      mplier_q,    mplier_d;
  logic [LEN_WORD-1:0]      w_data_q,    w_data_d;
  logic [LEN_PREG_ADDR-1:0] w_pa_rd_q,   w_pa_rd_d;
  logic [LEN_CONTEXT-1:0]   w_context_q, w_context_d;

  // -------------------------------------------------------------------------
  // Incoming instruction fields
  // -------------------------------------------------------------------------
  logic [LEN_CONTEXT-1:0]   in_ctx;
  logic [LEN_WORD-1:0]      in_rs1, in_rs2;
  logic [LEN_PREG_ADDR-1:0] in_rd;
  logic [6:0]               in_f7;
  logic [2:0]               in_f3;
  logic [SH_W-1:0]          in_sh;
  logic                     in_is_mul;

  assign in_ctx = e_exec_info[CTX_LSB +: LEN_CONTEXT];
  assign in_rs2 = e_exec_info[RS2_LSB +: LEN_WORD];
  assign in_rs1 = e_exec_info[RS1_LSB +: LEN_WORD];
  assign in_rd  = e_exec_info[RD_LSB  +: LEN_PREG_ADDR];
  assign in_f7  = e_exec_info[F7_LSB  +: 7];
  assign in_f3  = e_exec_info[F3_LSB  +: 3];
  assign in_sh  = in_rs2[SH_W-1:0];

  assign in_is_mul = (in_f7 == 7'b0000001) && (in_f3 == 3'b000);

  // Routing is the issuer's job, so exec_type and io_type are not decoded.
  logic unused_fields;
  assign unused_fields = ^{e_exec_info[ET_LSB +: LEN_EXEC_TYPE], e_exec_info[IO_LSB]};

  // -------------------------------------------------------------------------
  // Handshake and kill
  // -------------------------------------------------------------------------
  logic kill_held;  // the op already held in MUL/DONE belongs to a killed context
  logic kill_in;    // the op offered this cycle belongs to a killed context
  logic take;       // accepted and not discarded

  // Must stay a pure function of the live order input: the issuer reacts to
  // accepted within the same cycle.
  assign accepted  = order & ((state_q == S_IDLE) | ((state_q == S_DONE) & w_ack));
  assign kill_held = branch_hazard & (|(hazard_context_info & w_context_q))
                     & (state_q != S_IDLE);
  assign kill_in   = branch_hazard & (|(hazard_context_info & in_ctx));
  assign take      = accepted & ~kill_in;

  // -------------------------------------------------------------------------
  // Single-cycle ALU
  // -------------------------------------------------------------------------
  logic [LEN_WORD-1:0] alu_res;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    alu_res = '0;
    unique case (in_f3)
      3'b000: alu_res = in_f7[5] ? (in_rs1 - in_rs2) : (in_rs1 + in_rs2);
      3'b001: alu_res = in_rs1 << in_sh;
      3'b010: alu_res = {{(LEN_WORD-1){1'b0}}, ($signed(in_rs1) < $signed(in_rs2))};
      3'b011: alu_res = {{(LEN_WORD-1){1'b0}}, (in_rs1 < in_rs2)};
      3'b100: alu_res = in_rs1 ^ in_rs2;
      3'b101: alu_res = in_f7[5] ? LEN_WORD'($signed(in_rs1) >>> in_sh)
                                 : (in_rs1 >> in_sh);
      3'b110: alu_res = in_rs1 | in_rs2;
      3'b111: alu_res = in_rs1 & in_rs2;
      default: alu_res = '0;
    endcase
  end

  // One multiplier bit per cycle; the low half of the product is the same
  // for signed and unsigned operands, so no sign handling is needed.
  logic [LEN_WORD-1:0] acc_next;
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (take) state_d = in_is_mul ? S_MUL : S_DONE;
      end
      S_MUL: begin
        if (kill_held)          state_d = S_IDLE;
        else if (cnt_q == '1)   state_d = S_DONE;
      end
      S_DONE: begin
        // A new accept implies w_ack, so the held result is gone either way;
        // only the incoming op decides where we go.
        if (take)                      state_d = in_is_mul ? S_MUL : S_DONE;
        else if (w_ack || kill_held)   state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: datapath and output register inputs
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    w_data_d    = w_data_q;
    w_pa_rd_d   = w_pa_rd_q;
    w_context_d = w_context_q;

    if (take) begin
      w_pa_rd_d   = in_rd;
      w_context_d = in_ctx;
      if (in_is_mul) begin
        acc_d    = '0;
        mcand_d  = in_rs1;
        mplier_d = in_rs2;
        cnt_d    = '0;
      end else begin
        w_data_d = alu_res;
      end
    end else if (state_q == S_MUL) begin
      if (kill_held) begin
        cnt_d = '0;
      end else begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == '1) w_data_d = acc_next;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      w_data_q    <= '0;
      w_pa_rd_q   <= '0;
      w_context_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      w_data_q    <= w_data_d;
      w_pa_rd_q   <= w_pa_rd_d;
      w_context_q <= w_context_d;
    end
  end

  assign w_done    = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign w_data    = w_data_q;
  assign w_pa_rd   = w_pa_rd_q;
  assign w_context = w_context_q;

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Execution-side responder of the instruction window's issue handshake. Accepts one ready instruction per `order`/`accepted` handshake, decodes the packed exec info, computes RV32I integer ALU results in one cycle and RV32M `MUL` iteratively, and presents the result plus destination physical register to the register manager's write-back port. In-flight work is dropped when a branch hazard kills its context.

## Interface
- `LEN_WORD`, 32: data width.
- `LEN_PREG_ADDR`, 6: physical register address width.
- `LEN_CONTEXT`, 2: one-hot context tag width.
- `LEN_EXEC_TYPE`, 5: exec type field width.
- `LEN_EXEC_INFO`, derived: `LEN_EXEC_TYPE+1+3+7+LEN_PREG_ADDR+2*LEN_WORD+LEN_CONTEXT`.

Ports:
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset. Synchronous, active-high.
- `order` in 1: issuer offers an instruction this cycle.
- `accepted` out 1: combinational. The instruction is taken this cycle.
- `e_exec_info` in `LEN_EXEC_INFO`: packed fields, MSB to LSB: `exec_type`, `io_type`, `func3`, `func7`, `pa_rd`, `d_rs1`, `d_rs2`, `context`.
- `branch_hazard` in 1: flush request.
- `hazard_context_info` in `LEN_CONTEXT`: contexts to kill.
- `w_done` out 1: write-back valid.
- `w_pa_rd` out `LEN_PREG_ADDR`: destination physical register.
- `w_data` out `LEN_WORD`: result.
- `w_context` out `LEN_CONTEXT`: context of the result.
- `w_ack` in 1: register manager consumed the result this cycle.
- `busy` out 1: state is not IDLE.

## Operation
- States:
  - IDLE: empty.
  - MUL: iterating.
  - DONE: result held on `w_*`.
- `accepted = order & (IDLE | (DONE & w_ack))`.
  - The issuer relies on `accepted` in the same cycle. It must not depend on any registered version of `order`.
- On accept, latch `pa_rd`, `context`, `func3`, `func7`, `d_rs1`, `d_rs2`. `exec_type` and `io_type` are ignored; routing is the issuer's job.
- Accepted with `func7 == 7'b0000001` and `func3 == 000` → MUL. All other encodings → ALU, then DONE next cycle.
- ALU (`a = d_rs1`, `b = d_rs2`, `sh = b[4:0]`):
  - func3 000: ADD; SUB if `func7[5]`.
  - 001: SLL.
  - 010: SLT (signed).
  - 011: SLTU.
  - 100: XOR.
  - 101: SRL; SRA if `func7[5]`.
  - 110: OR.
  - 111: AND.
  - Comparisons return 0 or 1. Arithmetic wraps modulo 2^32.
- MUL: shift-add, one multiplier bit per cycle, 32 iterations, 5-bit counter.
  - Result is the low 32 bits of `d_rs1*d_rs2`. Signedness is irrelevant for the low half.
  - Counter wrap from 31 → DONE.
- DONE: `w_done=1`; `w_*` stable until `w_ack`.
  - `w_ack` without a new accept → IDLE.
  - `w_ack` with a new accept → ALU goes to DONE with the new result next cycle; MUL goes to MUL.
- Kill: `kill = branch_hazard & |(hazard_context_info & ctx)`.
  - `ctx` is the latched context in MUL/DONE. For an op being accepted this cycle, `ctx` is the incoming context.
  - Killed latched op → IDLE next cycle, no `w_done`. If killed in DONE, `w_done` still reads 1 this cycle, but the register manager must ignore it (it sees the same hazard).
  - Incoming op killed in its accept cycle: `accepted=1` (the issuer drops it) and the op is discarded.
  - Both the held and the incoming op killed → IDLE.
- `w_ack` while not DONE is ignored.

## Timing
- Reset (`rst` high at posedge), next cycle:
  - State IDLE.
  - `w_done=0`, `w_pa_rd=0`, `w_data=0`, `w_context=0`, `busy=0`.
  - Counter 0.
  - `accepted = order`.
- Reset mid-MUL or mid-DONE aborts; no write-back.
- ALU latency: accept at cycle T → `w_done` at T+1.
- MUL latency: accept at T → `w_done` at T+33. `busy` is high T+1..T+33.
- Back-to-back ALU with `w_ack` tied high: one result per cycle.
- All outputs except `accepted` are registered.

## Test plan
- Reset, then ALU ADD `0x00000005 + 0xFFFFFFFF` (func3 000, func7 0), `pa_rd=7` → `accepted` same cycle; next cycle `w_done=1`, `w_data=0x00000004`, `w_pa_rd=7`.
- SRA `0x80000000 >> 4` (func7 `0100000`) → `0xF8000000`. SLT `-1 < 1` → 1. SLTU `0xFFFFFFFF < 1` → 0.
- MUL `0xFFFFFFFF * 3` → `accepted`; `busy` for 33 cycles; `w_data=0xFFFFFFFD` at T+33. `order` held meanwhile sees `accepted=0`.
- Hold `w_ack=0` for 5 cycles after an ALU result → `w_*` stable, `accepted=0`. Then `w_ack=1` together with a new `order` (AND `0xF0F0 & 0x0FF0`) → `accepted=1`; next cycle `w_data=0x00F0`.
- MUL in flight with `context=2'b01`:
  - `branch_hazard=1`, `hazard_context_info=2'b10` → continues.
  - `hazard_context_info=2'b01` → IDLE next cycle, no `w_done`, `accepted` available again.
- `rst` asserted at MUL iteration 10 → all outputs zero next cycle; no later `w_done`.
